// File: rtl/mips_pkg.sv
// mips_pkg: shared fetch-state type and instruction size
package mips_pkg;
    typedef enum logic [1:0] {RUN, HALTING, HALTED} fetch_state_t;
    localparam int INST_BYTES = 4;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: registered-output circular queue with synchronous flush
module fetch_fifo #(
    parameter int W = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic do_push, do_pop;
    assign do_pop = pop && count != '0;
    assign do_push = push && (count != CW'(DEPTH) || do_pop);
    assign dout = mem[rd_ptr];
    always_ff @(posedge clk)
        if (do_push && !flush) mem[wr_ptr] <= din;
    always_ff @(posedge clk or negedge rst_b)
        if (!rst_b) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            rd_ptr <= rd_ptr + AW'(do_pop);
            wr_ptr <= wr_ptr + AW'(do_push);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
endmodule

// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: credit-limited instruction fetch with redirect drop and halt
module mips_fetch_unit import mips_pkg::*; #(
    parameter int XLEN = 32,
    parameter int DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_b,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            inst_valid,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt,
    output logic            halted
);
    localparam int CW = $clog2(DEPTH) + 2;
    localparam logic [XLEN-1:0] STEP = XLEN'(INST_BYTES);
    logic [XLEN-1:0] fetch_pc, resp_pc, target;
    logic [CW-1:0] outstanding, drop_cnt, out_nxt;
    logic [CW-2:0] count;
    logic [31+XLEN:0] head;
    fetch_state_t state, state_nxt;
    logic flush, rv, push, pop, grant;
    always_comb begin
        flush = state == RUN && redirect_valid && !halt;
        rv = imem_rvalid && outstanding != '0;
        push = rv && drop_cnt == '0;
        imem_req = rst_b && state == RUN && !redirect_valid && !halt &&
                   (CW'(count) + outstanding - drop_cnt < CW'(DEPTH));
        grant = imem_req && imem_gnt;
        out_nxt = outstanding + CW'(grant) - CW'(rv);
        state_nxt = (state == RUN && halt) ? HALTING :
                    (state == HALTING && out_nxt == '0) ? HALTED : state;
        target = redirect_pc & ~XLEN'(3);
        inst_valid = count != '0;
        pop = inst_valid && inst_ready;
        inst = inst_valid ? head[31+XLEN:XLEN] : '0;
        inst_pc = inst_valid ? head[XLEN-1:0] : RESET_PC;
    end
    assign imem_addr = fetch_pc;
    fetch_fifo #(.W(32 + XLEN), .DEPTH(DEPTH)) u_fifo (
        .clk(clk),
        .rst_b(rst_b),
        .flush(flush),
        .push(push),
        .pop(pop),
        .din({imem_rdata, resp_pc}),
        .dout(head),
        .count(count)
    );
    always_ff @(posedge clk or negedge rst_b)
        if (!rst_b) begin
            fetch_pc <= RESET_PC;
            resp_pc <= RESET_PC;
            outstanding <= '0;
            drop_cnt <= '0;
            state <= RUN;
            halted <= 1'b0;
        end else begin
            outstanding <= out_nxt;
            state <= state_nxt;
            halted <= state_nxt == HALTED;
            // the response arriving with the redirect is consumed now, so it is not counted for dropping
            fetch_pc <= flush ? target : grant ? fetch_pc + STEP : fetch_pc;
            resp_pc <= flush ? target : push ? resp_pc + STEP : resp_pc;
            drop_cnt <= flush ? outstanding - CW'(rv) : (rv && drop_cnt != '0) ? drop_cnt - 1'b1 : drop_cnt;
        end
endmodule

// File: tb/tb_mips_fetch_unit.sv
// tb_mips_fetch_unit: directed scenario bench for the fetch unit
module tb_mips_fetch_unit;
    logic clk = 0;
    logic rst_b = 0;
    logic imem_req, imem_gnt, imem_rvalid, inst_valid, inst_ready, redirect_valid, halt, halted;
    logic [31:0] imem_addr, imem_rdata, inst, inst_pc, redirect_pc;
    logic resp_en;
    logic [31:0] pend[$], glog[$], ppc[$], pinst[$];
    int errors = 0;
    int checks = 0;

    mips_fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk),
        .rst_b(rst_b),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .inst_valid(inst_valid),
        .inst(inst),
        .inst_pc(inst_pc),
        .inst_ready(inst_ready),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .halt(halt),
        .halted(halted)
    );

    initial forever #5 clk = ~clk;

    // memory model: in-order, one cycle after grant, word = ~address
    task tick();
        logic g, rv, p;
        logic [31:0] a, pp, pi;
        #2;
        g = imem_req && imem_gnt;
        a = imem_addr;
        rv = imem_rvalid;
        p = inst_valid && inst_ready;
        pp = inst_pc;
        pi = inst;
        @(posedge clk);
        #1;
        if (rv && pend.size() > 0) void'(pend.pop_front());
        if (g) begin
            pend.push_back(a);
            glog.push_back(a);
        end
        if (p) begin
            ppc.push_back(pp);
            pinst.push_back(pi);
        end
        imem_rvalid = resp_en && pend.size() > 0;
        imem_rdata = imem_rvalid ? ~pend[0] : 32'h0;
    endtask

    task apply_reset();
        rst_b = 0;
        imem_gnt = 0;
        imem_rvalid = 0;
        imem_rdata = 0;
        inst_ready = 0;
        redirect_valid = 0;
        redirect_pc = 0;
        halt = 0;
        resp_en = 1;
        pend.delete();
        glog.delete();
        ppc.delete();
        pinst.delete();
        @(posedge clk);
        #1;
        rst_b = 1;
    endtask

    task test_reset();
        rst_b = 0;
        imem_gnt = 1;
        imem_rvalid = 0;
        imem_rdata = 0;
        inst_ready = 1;
        redirect_valid = 0;
        redirect_pc = 0;
        halt = 0;
        #2;
        checks++;
        if (imem_req !== 0 || inst_valid !== 0 || halted !== 0) begin
            errors++;
            $display("FAIL reset_ctrl: req=%b valid=%b halted=%b want 0 0 0", imem_req, inst_valid, halted);
        end
        checks++;
        if (inst !== 32'h0 || inst_pc !== 32'h0 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: inst=%h pc=%h addr=%h want 0 0 0", inst, inst_pc, imem_addr);
        end
    endtask

    task test_stream();
        apply_reset();
        imem_gnt = 1;
        inst_ready = 1;
        tick();
        #2;
        checks++;
        if (inst_valid !== 0) begin
            errors++;
            $display("FAIL stream_latency: inst_valid=%b during first response want 0", inst_valid);
        end
        tick();
        #2;
        checks++;
        if (inst_valid !== 1 || inst_pc !== 32'h0 || inst !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL stream_first: valid=%b pc=%h inst=%h want 1 0 ffffffff", inst_valid, inst_pc, inst);
        end
        repeat (4) tick();
        checks++;
        if (glog.size() != 6) begin
            errors++;
            $display("FAIL stream_grants: got %0d grants want 6", glog.size());
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (glog.size() <= i || glog[i] !== 32'(i * 4)) begin
                errors++;
                $display("FAIL stream_addr%0d: got %h want %h", i, glog.size() > i ? glog[i] : 32'hx, 32'(i * 4));
            end
            checks++;
            if (ppc.size() <= i || ppc[i] !== 32'(i * 4) || pinst[i] !== ~32'(i * 4)) begin
                errors++;
                $display("FAIL stream_pop%0d: pc=%h inst=%h want %h %h", i,
                         ppc.size() > i ? ppc[i] : 32'hx, pinst.size() > i ? pinst[i] : 32'hx, 32'(i * 4), ~32'(i * 4));
            end
        end
    endtask

    task test_backpressure();
        apply_reset();
        imem_gnt = 1;
        inst_ready = 0;
        repeat (10) tick();
        #2;
        checks++;
        if (glog.size() != 4 || imem_req !== 0) begin
            errors++;
            $display("FAIL bp_full: grants=%0d req=%b want 4 0", glog.size(), imem_req);
        end
        checks++;
        if (inst_valid !== 1 || inst_pc !== 32'h0) begin
            errors++;
            $display("FAIL bp_head: valid=%b pc=%h want 1 0", inst_valid, inst_pc);
        end
        inst_ready = 1;
        tick();
        inst_ready = 0;
        repeat (5) tick();
        #2;
        checks++;
        if (glog.size() != 5 || imem_req !== 0 || ppc.size() != 1) begin
            errors++;
            $display("FAIL bp_one_pop: grants=%0d req=%b pops=%0d want 5 0 1", glog.size(), imem_req, ppc.size());
        end
        checks++;
        if (inst_pc !== 32'h4 || glog[4] !== 32'h10) begin
            errors++;
            $display("FAIL bp_next: head=%h last_grant=%h want 4 10", inst_pc, glog[glog.size()-1]);
        end
    endtask

    task test_redirect();
        apply_reset();
        inst_ready = 1;
        resp_en = 0;
        imem_gnt = 1;
        repeat (3) tick();
        imem_rvalid = 1;
        imem_rdata = ~pend[0];
        redirect_valid = 1;
        redirect_pc = 32'h103;
        #2;
        checks++;
        if (imem_req !== 0) begin
            errors++;
            $display("FAIL redir_req: req=%b during redirect want 0", imem_req);
        end
        resp_en = 1;
        tick();
        redirect_valid = 0;
        #2;
        checks++;
        if (inst_valid !== 0 || imem_req !== 1 || imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL redir_target: valid=%b req=%b addr=%h want 0 1 100", inst_valid, imem_req, imem_addr);
        end
        tick();
        #2;
        checks++;
        if (inst_valid !== 0) begin
            errors++;
            $display("FAIL redir_drop1: valid=%b pc=%h want 0", inst_valid, inst_pc);
        end
        tick();
        #2;
        checks++;
        if (inst_valid !== 0) begin
            errors++;
            $display("FAIL redir_drop2: valid=%b pc=%h want 0", inst_valid, inst_pc);
        end
        tick();
        #2;
        checks++;
        if (inst_valid !== 1 || inst_pc !== 32'h100 || inst !== ~32'h100) begin
            errors++;
            $display("FAIL redir_first: valid=%b pc=%h inst=%h want 1 100 %h", inst_valid, inst_pc, inst, ~32'h100);
        end
    endtask

    task test_wrap();
        apply_reset();
        redirect_valid = 1;
        redirect_pc = 32'hFFFFFFFC;
        tick();
        redirect_valid = 0;
        imem_gnt = 1;
        #2;
        checks++;
        if (imem_addr !== 32'hFFFFFFFC) begin
            errors++;
            $display("FAIL wrap_addr0: got %h want fffffffc", imem_addr);
        end
        tick();
        #2;
        checks++;
        if (imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_addr1: got %h want 0", imem_addr);
        end
        tick();
        imem_gnt = 0;
        #2;
        checks++;
        if (inst_valid !== 1 || inst_pc !== 32'hFFFFFFFC || inst !== 32'h3) begin
            errors++;
            $display("FAIL wrap_pc0: valid=%b pc=%h inst=%h want 1 fffffffc 3", inst_valid, inst_pc, inst);
        end
        inst_ready = 1;
        tick();
        #2;
        checks++;
        if (inst_valid !== 1 || inst_pc !== 32'h0 || inst !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL wrap_pc1: valid=%b pc=%h inst=%h want 1 0 ffffffff", inst_valid, inst_pc, inst);
        end
    endtask

    task test_halt();
        apply_reset();
        resp_en = 0;
        imem_gnt = 1;
        repeat (2) tick();
        halt = 1;
        #2;
        checks++;
        if (imem_req !== 0) begin
            errors++;
            $display("FAIL halt_req: req=%b with halt want 0", imem_req);
        end
        tick();
        halt = 0;
        resp_en = 1;
        imem_rvalid = 1;
        imem_rdata = ~pend[0];
        #2;
        checks++;
        if (imem_req !== 0 || halted !== 0) begin
            errors++;
            $display("FAIL halt_draining: req=%b halted=%b want 0 0", imem_req, halted);
        end
        tick();
        #2;
        checks++;
        if (halted !== 0 || imem_rvalid !== 1) begin
            errors++;
            $display("FAIL halt_early: halted=%b rvalid=%b want 0 1", halted, imem_rvalid);
        end
        tick();
        #2;
        checks++;
        if (halted !== 1) begin
            errors++;
            $display("FAIL halt_rise: halted=%b want 1", halted);
        end
        redirect_valid = 1;
        redirect_pc = 32'h200;
        tick();
        redirect_valid = 0;
        #2;
        checks++;
        if (inst_valid !== 1 || inst_pc !== 32'h0 || imem_req !== 0 || imem_addr !== 32'h8) begin
            errors++;
            $display("FAIL halt_redirect: valid=%b pc=%h req=%b addr=%h want 1 0 0 8", inst_valid, inst_pc, imem_req, imem_addr);
        end
        inst_ready = 1;
        tick();
        #2;
        checks++;
        if (inst_valid !== 1 || inst_pc !== 32'h4 || inst !== ~32'h4) begin
            errors++;
            $display("FAIL halt_pop: valid=%b pc=%h inst=%h want 1 4 %h", inst_valid, inst_pc, inst, ~32'h4);
        end
        tick();
        #2;
        checks++;
        if (inst_valid !== 0 || halted !== 1 || glog.size() != 2) begin
            errors++;
            $display("FAIL halt_end: valid=%b halted=%b grants=%0d want 0 1 2", inst_valid, halted, glog.size());
        end
    endtask

    task test_reset_mid();
        apply_reset();
        resp_en = 0;
        imem_gnt = 1;
        repeat (3) tick();
        #2;
        checks++;
        if (imem_req !== 1 || imem_addr !== 32'hC) begin
            errors++;
            $display("FAIL rstmid_pre: req=%b addr=%h want 1 c", imem_req, imem_addr);
        end
        rst_b = 0;
        #1;
        checks++;
        if (imem_req !== 0 || imem_addr !== 32'h0 || inst_valid !== 0 || halted !== 0 ||
            inst !== 32'h0 || inst_pc !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_async: req=%b addr=%h valid=%b halted=%b inst=%h pc=%h want 0 0 0 0 0 0",
                     imem_req, imem_addr, inst_valid, halted, inst, inst_pc);
        end
        imem_rvalid = 0;
        pend.delete();
        @(posedge clk);
        #1;
        rst_b = 1;
        glog.delete();
        tick();
        checks++;
        if (glog.size() != 1 || glog[0] !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_restart: grants=%0d first=%h want 1 0", glog.size(), glog.size() > 0 ? glog[0] : 32'hx);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_halt();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
